// File: rtl/alu_serial_rx.sv
// Receive front end of the serial ALU: deserialises 11-bit packets into a command frame,
// validates length/CRC4/opcode and hands {A, B, OP, err} to the core over valid/ready.
module alu_serial_rx #(
   parameter int DW          = 32,
   parameter int SYNC_STAGES = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          sin,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_a,
   output logic [DW-1:0] out_b,
   output logic [2:0]    out_op,
   output logic [2:0]    out_err,
   output logic          overrun
);

   localparam int NPKT = 2 * DW / 8;
   localparam int CW   = $clog2(NPKT + 2);
   localparam logic [CW-1:0] NPKT_C   = CW'(NPKT);
   localparam logic [CW-1:0] NPKT_SAT = CW'(NPKT + 1);

   typedef enum logic [2:0] {IDLE, TYPE, BITS, STOP, FLUSH} state_t;

   logic            sin_s;
   state_t          state;
   logic            pkt_type;
   logic [2:0]      bit_cnt;
   logic [7:0]      byte_sr;
   logic [2*DW-1:0] opnd;
   logic [CW-1:0]   pkt_cnt;
   logic            frame_err;

   logic [2:0]      ctl_op;
   logic [3:0]      ctl_crc;
   logic            err_data;
   logic            err_crc;
   logic            err_op;

   // Synchroniser flops reset to the idle-high line level so reset never looks like a start bit.
   generate
      if (SYNC_STAGES == 0) begin : g_nosync
         assign sin_s = sin;
      end else begin : g_sync
         logic [SYNC_STAGES-1:0] sync_q;
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               sync_q <= '1;
            end else begin
               sync_q[0] <= sin;
               for (int i = 1; i < SYNC_STAGES; i++) begin
                  sync_q[i] <= sync_q[i-1];
               end
            end
         end
         assign sin_s = sync_q[SYNC_STAGES-1];
      end
   endgenerate

   function automatic logic [3:0] crc4(input logic [2*DW+3:0] msg);
      logic [3:0] c;
      logic       fb;
      c = 4'h0;
      for (int i = 2*DW+3; i >= 0; i--) begin
         fb = c[3] ^ msg[i];
         c  = {c[2:0], 1'b0} ^ (fb ? 4'b0011 : 4'b0000);
      end
      return c;
   endfunction

   // Frame verdict, evaluated while the CTL byte sits in byte_sr during its stop bit.
   always_comb begin
      ctl_op   = byte_sr[6:4];
      ctl_crc  = byte_sr[3:0];
      err_data = (pkt_cnt != NPKT_C) || frame_err;
      err_crc  = !err_data && (ctl_crc != crc4({opnd, 1'b1, ctl_op}));
      err_op   = !err_data && !err_crc &&
                 !(ctl_op == 3'b000 || ctl_op == 3'b001 || ctl_op == 3'b100 || ctl_op == 3'b101);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         pkt_type  <= 1'b0;
         bit_cnt   <= 3'd0;
         byte_sr   <= 8'h00;
         opnd      <= '0;
         pkt_cnt   <= '0;
         frame_err <= 1'b0;
         out_valid <= 1'b0;
         out_a     <= '0;
         out_b     <= '0;
         out_op    <= 3'b000;
         out_err   <= 3'b000;
         overrun   <= 1'b0;
      end else begin
         overrun <= 1'b0;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (!sin_s) begin
                  state <= TYPE;
               end
            end
            TYPE: begin
               pkt_type <= sin_s;
               bit_cnt  <= 3'd7;
               state    <= BITS;
            end
            BITS: begin
               byte_sr <= {byte_sr[6:0], sin_s};
               bit_cnt <= bit_cnt - 3'd1;
               if (bit_cnt == 3'd0) begin
                  state <= STOP;
               end
            end
            STOP: begin
               if (sin_s) begin
                  state <= IDLE;
                  if (!pkt_type) begin
                     opnd <= {opnd[2*DW-9:0], byte_sr};
                     if (pkt_cnt != NPKT_SAT) begin
                        pkt_cnt <= pkt_cnt + 1'b1;
                     end
                  end else begin
                     opnd      <= '0;
                     pkt_cnt   <= '0;
                     frame_err <= 1'b0;
                     // A held, unconsumed result wins; the new frame is dropped and flagged.
                     if (!out_valid || out_ready) begin
                        out_valid <= 1'b1;
                        out_b     <= opnd[2*DW-1:DW];
                        out_a     <= opnd[DW-1:0];
                        out_op    <= ctl_op;
                        out_err   <= {err_data, err_crc, err_op};
                     end else begin
                        overrun <= 1'b1;
                     end
                  end
               end else begin
                  state     <= FLUSH;
                  frame_err <= 1'b1;
                  pkt_cnt   <= '0;
               end
            end
            FLUSH: begin
               if (sin_s) begin
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_serial_rx.sv
// Self-checking bench for alu_serial_rx: frames are built serially, expected results are
// queued as each frame is driven and popped when the receiver presents its output.
module tb_alu_serial_rx;

   localparam int DW = 32;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  op;
      logic [2:0]  err;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          sin;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_a;
   logic [DW-1:0] out_b;
   logic [2:0]    out_op;
   logic [2:0]    out_err;
   logic          overrun;

   exp_t sb[$];
   int   n_cmp    = 0;
   int   n_bad    = 0;
   int   ovr_cnt  = 0;
   int   xfer_cnt = 0;

   alu_serial_rx #(.DW(DW), .SYNC_STAGES(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .sin       (sin),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_op    (out_op),
      .out_err   (out_err),
      .overrun   (overrun)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (overrun) ovr_cnt++;
      if (out_valid && out_ready) xfer_cnt++;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "[TB] watchdog expired");
   end

   // Remainder of {B, A, 1, OP} * x^4 modulo x^4+x+1, by long division.
   function automatic logic [3:0] ref_crc(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] op);
      logic [71:0] msg;
      logic [3:0]  rem;
      logic        top;
      msg = {b, a, 1'b1, op, 4'b0000};
      rem = 4'h0;
      for (int i = 71; i >= 0; i--) begin
         top = rem[3];
         rem = {rem[2:0], msg[i]};
         if (top) rem = rem ^ 4'b0011;
      end
      return rem;
   endfunction

   task automatic send_bit(input logic b);
      @(negedge clk);
      sin = b;
   endtask

   task automatic send_packet(input logic typ, input logic [7:0] data, input logic stop_bit);
      send_bit(1'b0);
      send_bit(typ);
      for (int i = 7; i >= 0; i--) send_bit(data[i]);
      send_bit(stop_bit);
   endtask

   task automatic send_frame(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                             input logic [3:0] crc_flip, input int ndata);
      logic [63:0] ba;
      ba = {b, a};
      for (int k = 0; k < ndata; k++) send_packet(1'b0, ba[63-8*k -: 8], 1'b1);
      send_packet(1'b1, {1'b0, op, ref_crc(a, b, op) ^ crc_flip}, 1'b1);
   endtask

   task automatic wait_valid(input int budget, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < budget && !seen; i++) begin
         @(negedge clk);
         if (out_valid) seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      rst = 1'b1; sin = 1'b1; out_ready = 1'b1;
      repeat (3) @(negedge clk);
      n_cmp++;
      if ({out_valid, overrun, out_a, out_b, out_op, out_err} !== '0) begin
         n_bad++;
         $display("[TB] FAIL reset_outputs: got v=%b ovr=%b a=%h b=%h op=%b err=%b, want all zero",
                  out_valid, overrun, out_a, out_b, out_op, out_err);
      end
      @(posedge clk); #1 rst = 1'b0;
      repeat (5) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL reset_idle_valid: got %b, want 0", out_valid);
      end
   endtask

   task automatic test_good_add;
      exp_t e;
      bit   seen;
      sb.push_back({32'h0000_0003, 32'h0000_0005, 3'b100, 3'b000});
      send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen) begin
         n_bad++;
         $display("[TB] FAIL add_valid: got out_valid=0, want 1 within 20 cycles");
      end else begin
         n_cmp++;
         if ({out_a, out_b, out_op, out_err} !== e) begin
            n_bad++;
            $display("[TB] FAIL add_frame: got a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                     out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
         end
         @(negedge clk);
         n_cmp++;
         if (out_valid !== 1'b0) begin
            n_bad++;
            $display("[TB] FAIL add_valid_pulse: got out_valid=%b after accept, want 0", out_valid);
         end
      end
   endtask

   task automatic test_short_frame;
      exp_t e;
      bit   seen;
      sb.push_back({32'h0000_0003, 32'h0000_0005, 3'b100, 3'b100});
      send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0, 7);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || out_err !== e.err) begin
         n_bad++;
         $display("[TB] FAIL short_err: got valid=%b err=%b, want valid=1 err=%b", seen, out_err, e.err);
      end
      sb.push_back({32'h0000_0003, 32'h0000_0005, 3'b100, 3'b000});
      send_frame(32'h0000_0003, 32'h0000_0005, 3'b100, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL short_recover: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
   endtask

   task automatic test_crc_error;
      exp_t e;
      bit   seen;
      sb.push_back({32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 3'b010});
      send_frame(32'hFFFF_FFFF, 32'h0000_0001, 3'b101, 4'h1, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL crc_err: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
   endtask

   task automatic test_op_and_framing;
      exp_t e;
      bit   seen;
      sb.push_back({32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 3'b001});
      send_frame(32'h1234_5678, 32'h9ABC_DEF0, 3'b111, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL op_err: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
      // Packet 3 carries a zero stop bit; the frame is abandoned after a short idle gap.
      send_packet(1'b0, 8'hA5, 1'b1);
      send_packet(1'b0, 8'h5A, 1'b1);
      send_packet(1'b0, 8'h3C, 1'b0);
      repeat (3) send_bit(1'b1);
      sb.push_back({32'h0000_0011, 32'h0000_0022, 3'b000, 3'b100});
      send_frame(32'h0000_0011, 32'h0000_0022, 3'b000, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || out_err !== e.err) begin
         n_bad++;
         $display("[TB] FAIL framing_err: got valid=%b err=%b, want valid=1 err=%b", seen, out_err, e.err);
      end
      sb.push_back({32'h0000_0011, 32'h0000_0022, 3'b001, 3'b000});
      send_frame(32'h0000_0011, 32'h0000_0022, 3'b001, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL framing_recover: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
   endtask

   task automatic test_overrun;
      exp_t e;
      bit   seen;
      int   ovr0;
      int   xfer0;
      @(posedge clk); #1 out_ready = 1'b0;
      ovr0 = ovr_cnt;
      sb.push_back({32'h0000_000A, 32'h0000_0014, 3'b100, 3'b000});
      send_frame(32'h0000_000A, 32'h0000_0014, 3'b100, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL hold_first: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
      send_frame(32'h0000_0007, 32'h0000_0009, 3'b000, 4'h0, 8);
      repeat (8) @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b1 || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL hold_stable: got valid=%b a=%h b=%h op=%b err=%b, want valid=1 a=%h b=%h op=%b err=%b",
                  out_valid, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
      #1;
      n_cmp++;
      if (ovr_cnt - ovr0 !== 1) begin
         n_bad++;
         $display("[TB] FAIL overrun_pulses: got %0d, want 1", ovr_cnt - ovr0);
      end
      @(posedge clk); #1 out_ready = 1'b1;
      xfer0 = xfer_cnt;
      @(negedge clk);
      @(negedge clk);
      n_cmp++;
      if (out_valid !== 1'b0) begin
         n_bad++;
         $display("[TB] FAIL release_valid: got out_valid=%b, want 0", out_valid);
      end
      #1;
      n_cmp++;
      if (xfer_cnt - xfer0 !== 1) begin
         n_bad++;
         $display("[TB] FAIL release_xfers: got %0d, want 1", xfer_cnt - xfer0);
      end
   endtask

   task automatic test_reset_midframe;
      exp_t        e;
      bit          seen;
      int          xfer0;
      logic [63:0] ba;
      xfer0 = xfer_cnt;
      ba = {32'h0000_00BB, 32'h0000_00AA};
      for (int k = 0; k < 4; k++) send_packet(1'b0, ba[63-8*k -: 8], 1'b1);
      send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
      @(posedge clk); #1 rst = 1'b1; sin = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      repeat (10) @(negedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0 || xfer_cnt != xfer0) begin
         n_bad++;
         $display("[TB] FAIL abort_no_output: got valid=%b xfers=%0d, want valid=0 xfers=0",
                  out_valid, xfer_cnt - xfer0);
      end
      sb.push_back({32'hCAFE_0001, 32'h0BAD_0002, 3'b101, 3'b000});
      send_frame(32'hCAFE_0001, 32'h0BAD_0002, 3'b101, 4'h0, 8);
      wait_valid(20, seen);
      e = sb.pop_front();
      n_cmp++;
      if (!seen || {out_a, out_b, out_op, out_err} !== e) begin
         n_bad++;
         $display("[TB] FAIL abort_recover: got valid=%b a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                  seen, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
      end
   endtask

   task automatic test_back_to_back;
      exp_t e;
      int   got;
      got = 0;
      sb.push_back({32'h0000_0100, 32'h0000_0200, 3'b001, 3'b000});
      sb.push_back({32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, 3'b000});
      fork
         begin
            send_frame(32'h0000_0100, 32'h0000_0200, 3'b001, 4'h0, 8);
            send_frame(32'h0F0F_0F0F, 32'hF0F0_F0F0, 3'b000, 4'h0, 8);
         end
         begin
            for (int i = 0; i < 300 && got < 2; i++) begin
               @(negedge clk);
               if (out_valid && sb.size() > 0) begin
                  got++;
                  e = sb.pop_front();
                  n_cmp++;
                  if ({out_a, out_b, out_op, out_err} !== e) begin
                     n_bad++;
                     $display("[TB] FAIL b2b_frame%0d: got a=%h b=%h op=%b err=%b, want a=%h b=%h op=%b err=%b",
                              got, out_a, out_b, out_op, out_err, e.a, e.b, e.op, e.err);
                  end
               end
            end
         end
      join
      n_cmp++;
      if (got != 2) begin
         n_bad++;
         $display("[TB] FAIL b2b_count: got %0d frames, want 2", got);
      end
   endtask

   initial begin
      $display("[TB] starting alu_serial_rx bench");
      test_reset();
      test_good_add();
      test_short_frame();
      test_crc_error();
      test_op_and_framing();
      test_overrun();
      test_reset_midframe();
      test_back_to_back();
      repeat (5) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
